// File: rtl/hazard_tracker_if.sv
// Decode-side hazard bundle: per-instruction hazard fields from the decoder,
// MDU status and flush going in; stall and forwarding selects coming back.
interface hazard_tracker_if #(
  parameter int AW     = 5,
  parameter int TW     = 2,
  parameter int STAGES = 3
);
  localparam int SW = $clog2(STAGES + 1);

  logic          d_valid;
  logic [AW-1:0] d_rs;
  logic [AW-1:0] d_rt;
  logic          d_read_rs;
  logic          d_read_rt;
  logic [TW-1:0] d_tuse_rs;
  logic [TW-1:0] d_tuse_rt;
  logic [AW-1:0] d_a3;
  logic [TW-1:0] d_tnew;
  logic          d_is_md;
  logic          mdu_busy;
  logic          mdu_start;
  logic          flush;
  logic          stall;
  logic [SW-1:0] fwd_rs_sel;
  logic [SW-1:0] fwd_rt_sel;

  modport master (
    output d_valid, d_rs, d_rt, d_read_rs, d_read_rt, d_tuse_rs, d_tuse_rt,
           d_a3, d_tnew, d_is_md, mdu_busy, mdu_start, flush,
    input  stall, fwd_rs_sel, fwd_rt_sel
  );

  modport slave (
    input  d_valid, d_rs, d_rt, d_read_rs, d_read_rt, d_tuse_rs, d_tuse_rt,
           d_a3, d_tnew, d_is_md, mdu_busy, mdu_start, flush,
    output stall, fwd_rs_sel, fwd_rt_sel
  );
endinterface

// File: rtl/hazard_tracker.sv
// Hazard and forwarding tracker for the pipelined MIPS core. Keeps one
// (destination, remaining-Tnew) record per post-decode stage and derives the
// decode stall and the forwarding-source selects from them.
module hazard_tracker #(
  parameter int AW       = 5,
  parameter int TW       = 2,
  parameter int STAGES   = 3,
  parameter int MD_BLOCK = 1
) (
  input logic             clk,
  input logic             reset,
  hazard_tracker_if.slave hz
);
  localparam int SW = $clog2(STAGES + 1);

  // Stage k: 1 = E, 2 = M, 3 = W, ...
  logic [AW-1:0] a3_r   [1:STAGES];
  logic [TW-1:0] tnew_r [1:STAGES];

  logic          hazard_rs;
  logic          hazard_rt;
  logic          md_stall;
  logic          stall_int;
  logic [SW-1:0] fwd_rs;
  logic [SW-1:0] fwd_rt;

  // Remaining-Tnew countdown that bottoms out at zero.
  function automatic logic [TW-1:0] dec_sat(input logic [TW-1:0] x);
    return (x == '0) ? '0 : (x - TW'(1));
  endfunction

  // A source matches a record only when it is really read and is not $0.
  function automatic logic src_match(input logic          rd,
                                     input logic [AW-1:0] src,
                                     input logic [AW-1:0] dst);
    return rd && (src != '0) && (dst == src);
  endfunction

  // Scan oldest to youngest so the youngest matching writer sets the select last.
  always_comb begin
    hazard_rs = 1'b0;
    hazard_rt = 1'b0;
    fwd_rs    = '0;
    fwd_rt    = '0;
    for (int k = STAGES; k >= 1; k--) begin
      fwd_rs    = src_match(hz.d_read_rs, hz.d_rs, a3_r[k]) ? SW'(k) : fwd_rs;
      fwd_rt    = src_match(hz.d_read_rt, hz.d_rt, a3_r[k]) ? SW'(k) : fwd_rt;
      hazard_rs = hazard_rs |
                  (src_match(hz.d_read_rs, hz.d_rs, a3_r[k]) && (tnew_r[k] > hz.d_tuse_rs));
      hazard_rt = hazard_rt |
                  (src_match(hz.d_read_rt, hz.d_rt, a3_r[k]) && (tnew_r[k] > hz.d_tuse_rt));
    end
  end

  // Decode freezes on an unready source or on an MDU-class op meeting a busy MDU.
  always_comb begin
    md_stall  = (MD_BLOCK != 0) && hz.d_valid && hz.d_is_md && (hz.mdu_busy || hz.mdu_start);
    stall_int = hz.d_valid && (hazard_rs || hazard_rt || md_stall);
  end

  assign hz.stall      = stall_int;
  assign hz.fwd_rs_sel = fwd_rs;
  assign hz.fwd_rt_sel = fwd_rt;

  // Advance records one stage per edge; reset and flush empty every stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 1; k <= STAGES; k++) begin
        a3_r[k]   <= '0;
        tnew_r[k] <= '0;
      end
    end else if (hz.flush) begin
      for (int k = 1; k <= STAGES; k++) begin
        a3_r[k]   <= '0;
        tnew_r[k] <= '0;
      end
    end else begin
      if (hz.d_valid && !stall_int) begin
        a3_r[1]   <= hz.d_a3;
        tnew_r[1] <= dec_sat(hz.d_tnew);
      end else begin
        a3_r[1]   <= '0;
        tnew_r[1] <= '0;
      end
      for (int k = 2; k <= STAGES; k++) begin
        a3_r[k]   <= a3_r[k-1];
        tnew_r[k] <= dec_sat(tnew_r[k-1]);
      end
    end
  end
endmodule

// File: tb/tb_hazard_tracker.sv
// Directed bench for hazard_tracker (STAGES = 3). Stimulus pushes expected
// outputs into a queue; a monitor process pops and compares them. A second
// instance with MD_BLOCK = 0 sees the same inputs.
module tb_hazard_tracker;
  logic clk;
  logic reset;

  logic       d_valid;
  logic [4:0] d_rs;
  logic [4:0] d_rt;
  logic       d_read_rs;
  logic       d_read_rt;
  logic [1:0] d_tuse_rs;
  logic [1:0] d_tuse_rt;
  logic [4:0] d_a3;
  logic [1:0] d_tnew;
  logic       d_is_md;
  logic       mdu_busy;
  logic       mdu_start;
  logic       flush;

  hazard_tracker_if #(.AW(5), .TW(2), .STAGES(3)) hz1 ();
  hazard_tracker_if #(.AW(5), .TW(2), .STAGES(3)) hz2 ();

  assign hz1.d_valid = d_valid;   assign hz2.d_valid = d_valid;
  assign hz1.d_rs = d_rs;         assign hz2.d_rs = d_rs;
  assign hz1.d_rt = d_rt;         assign hz2.d_rt = d_rt;
  assign hz1.d_read_rs = d_read_rs; assign hz2.d_read_rs = d_read_rs;
  assign hz1.d_read_rt = d_read_rt; assign hz2.d_read_rt = d_read_rt;
  assign hz1.d_tuse_rs = d_tuse_rs; assign hz2.d_tuse_rs = d_tuse_rs;
  assign hz1.d_tuse_rt = d_tuse_rt; assign hz2.d_tuse_rt = d_tuse_rt;
  assign hz1.d_a3 = d_a3;         assign hz2.d_a3 = d_a3;
  assign hz1.d_tnew = d_tnew;     assign hz2.d_tnew = d_tnew;
  assign hz1.d_is_md = d_is_md;   assign hz2.d_is_md = d_is_md;
  assign hz1.mdu_busy = mdu_busy; assign hz2.mdu_busy = mdu_busy;
  assign hz1.mdu_start = mdu_start; assign hz2.mdu_start = mdu_start;
  assign hz1.flush = flush;       assign hz2.flush = flush;

  hazard_tracker #(.AW(5), .TW(2), .STAGES(3), .MD_BLOCK(1)) dut (
    .clk(clk), .reset(reset), .hz(hz1)
  );
  hazard_tracker #(.AW(5), .TW(2), .STAGES(3), .MD_BLOCK(0)) dut_nomd (
    .clk(clk), .reset(reset), .hz(hz2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       stall;
    logic [1:0] fwd_rs;
    logic [1:0] fwd_rt;
    logic       stall2;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  event chk_ev;
  int   vectors    = 0;
  int   miscompares = 0;

  // Monitor: pop one expectation per sample request and compare.
  always begin
    @(chk_ev);
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL monitor: sample requested with empty queue (got 0 entries, need 1)");
    end else begin
      cur = exp_q.pop_front();
      vectors++;
      if (hz1.stall !== cur.stall || hz1.fwd_rs_sel !== cur.fwd_rs ||
          hz1.fwd_rt_sel !== cur.fwd_rt || hz2.stall !== cur.stall2) begin
        miscompares++;
        $display("FAIL %s: got stall=%b rs_sel=%0d rt_sel=%0d stall_nomd=%b, expected stall=%b rs_sel=%0d rt_sel=%0d stall_nomd=%b",
                 cur.name, hz1.stall, hz1.fwd_rs_sel, hz1.fwd_rt_sel, hz2.stall,
                 cur.stall, cur.fwd_rs, cur.fwd_rt, cur.stall2);
      end
    end
  end

  task automatic idle();
    d_valid = 1'b0; d_rs = 5'd0; d_rt = 5'd0; d_read_rs = 1'b0; d_read_rt = 1'b0;
    d_tuse_rs = 2'd0; d_tuse_rt = 2'd0; d_a3 = 5'd0; d_tnew = 2'd0;
    d_is_md = 1'b0; mdu_busy = 1'b0; mdu_start = 1'b0; flush = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic do_reset();
    next_cycle();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic expect_now(input string n, input logic s, input logic [1:0] r,
                            input logic [1:0] t, input logic s2);
    exp_t e;
    #1;
    e.name = n; e.stall = s; e.fwd_rs = r; e.fwd_rt = t; e.stall2 = s2;
    exp_q.push_back(e);
    ->chk_ev;
    #1;
  endtask

  task automatic writer(input logic [4:0] a3, input logic [1:0] tnew);
    d_valid = 1'b1; d_a3 = a3; d_tnew = tnew;
  endtask

  task automatic read_rs(input logic [4:0] r, input logic [1:0] tuse);
    d_rs = r; d_read_rs = 1'b1; d_tuse_rs = tuse;
  endtask

  task automatic read_rt(input logic [4:0] r, input logic [1:0] tuse);
    d_rt = r; d_read_rt = 1'b1; d_tuse_rt = tuse;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    do_reset();

    // Reset state: records empty, a real reader sees nothing
    d_valid = 1'b1; read_rs(5'd8, 2'd0); read_rt(5'd9, 2'd0);
    expect_now("reset_clear", 1'b0, 2'd0, 2'd0, 1'b0);

    // Load-use: lw $8 then add reading $8 with tuse 1
    next_cycle(); writer(5'd8, 2'd3);
    expect_now("lw_issue", 1'b0, 2'd0, 2'd0, 1'b0);
    next_cycle(); writer(5'd11, 2'd2); read_rs(5'd8, 2'd1);
    expect_now("loaduse_c1", 1'b1, 2'd1, 2'd0, 1'b1);
    next_cycle(); writer(5'd11, 2'd2); read_rs(5'd8, 2'd1);
    expect_now("loaduse_c2", 1'b0, 2'd2, 2'd0, 1'b0);

    // ALU to branch: add $9 then beq reading $9 (and $0) in D
    do_reset();
    writer(5'd9, 2'd2);
    expect_now("alu_issue", 1'b0, 2'd0, 2'd0, 1'b0);
    next_cycle(); d_valid = 1'b1; read_rs(5'd9, 2'd0); read_rt(5'd0, 2'd0);
    expect_now("alu_br_stall", 1'b1, 2'd1, 2'd0, 1'b1);
    next_cycle(); d_valid = 1'b1; read_rs(5'd9, 2'd0); read_rt(5'd0, 2'd0);
    expect_now("alu_br_go", 1'b0, 2'd2, 2'd0, 1'b0);

    // Youngest priority: E and M both hold $10 with tnew 0
    do_reset();
    writer(5'd10, 2'd1);
    expect_now("w10_a", 1'b0, 2'd0, 2'd0, 1'b0);
    next_cycle(); writer(5'd10, 2'd1);
    expect_now("w10_b", 1'b0, 2'd0, 2'd0, 1'b0);
    next_cycle(); d_valid = 1'b1; read_rs(5'd10, 2'd1); read_rt(5'd10, 2'd0);
    expect_now("youngest", 1'b0, 2'd1, 2'd1, 1'b0);
    d_read_rs = 1'b0;
    expect_now("no_read_rs", 1'b0, 2'd0, 2'd1, 1'b0);

    // Register zero: writer to $0 with tnew 3 never blocks a $0 reader
    do_reset();
    writer(5'd0, 2'd3);
    expect_now("w0_issue", 1'b0, 2'd0, 2'd0, 1'b0);
    next_cycle(); d_valid = 1'b1; read_rs(5'd0, 2'd0); read_rt(5'd0, 2'd0);
    expect_now("reg_zero", 1'b0, 2'd0, 2'd0, 1'b0);

    // MDU busy for 5 cycles: stall each cycle, stage 1 stays a bubble
    do_reset();
    for (int c = 0; c < 5; c++) begin
      writer(5'd5, 2'd2); d_is_md = 1'b1; mdu_busy = 1'b1; read_rt(5'd5, 2'd3);
      expect_now("mdu_busy", 1'b1, 2'd0, 2'd0, 1'b0);
      next_cycle();
    end
    writer(5'd5, 2'd2); d_is_md = 1'b1; read_rt(5'd5, 2'd3);
    expect_now("mdu_release", 1'b0, 2'd0, 2'd0, 1'b0);
    next_cycle(); read_rt(5'd5, 2'd3);
    expect_now("mdu_entered", 1'b0, 2'd0, 2'd1, 1'b0);
    next_cycle(); d_valid = 1'b1; d_is_md = 1'b1; mdu_start = 1'b1;
    expect_now("mdu_start", 1'b1, 2'd0, 2'd0, 1'b0);
    d_valid = 1'b0;
    expect_now("md_invalid", 1'b0, 2'd0, 2'd0, 1'b0);

    // Record ages out after stage 3; stall tracks remaining tnew
    do_reset();
    writer(5'd8, 2'd3);
    expect_now("age_issue", 1'b0, 2'd0, 2'd0, 1'b0);
    next_cycle(); read_rs(5'd8, 2'd0);
    expect_now("age_e_idle", 1'b0, 2'd1, 2'd0, 1'b0);
    d_valid = 1'b1;
    expect_now("age_e_valid", 1'b1, 2'd1, 2'd0, 1'b1);
    next_cycle(); read_rs(5'd8, 2'd0);
    expect_now("age_m_idle", 1'b0, 2'd2, 2'd0, 1'b0);
    d_valid = 1'b1;
    expect_now("age_m_valid", 1'b1, 2'd2, 2'd0, 1'b1);
    next_cycle(); read_rs(5'd8, 2'd0); d_valid = 1'b1;
    expect_now("age_w_valid", 1'b0, 2'd3, 2'd0, 1'b0);
    d_valid = 1'b0;
    next_cycle(); d_valid = 1'b1; read_rs(5'd8, 2'd0);
    expect_now("age_gone", 1'b0, 2'd0, 2'd0, 1'b0);

    // Flush wins over a concurrent stall
    do_reset();
    writer(5'd8, 2'd3);
    expect_now("flush_lw", 1'b0, 2'd0, 2'd0, 1'b0);
    next_cycle(); d_valid = 1'b1; read_rs(5'd8, 2'd0); flush = 1'b1;
    expect_now("flush_cycle", 1'b1, 2'd1, 2'd0, 1'b1);
    next_cycle(); d_valid = 1'b1; read_rs(5'd8, 2'd0);
    expect_now("after_flush", 1'b0, 2'd0, 2'd0, 1'b0);

    // Asynchronous reset mid-stall drops stall before the next edge
    do_reset();
    writer(5'd8, 2'd3);
    expect_now("rst_lw", 1'b0, 2'd0, 2'd0, 1'b0);
    next_cycle(); d_valid = 1'b1; read_rs(5'd8, 2'd0);
    expect_now("pre_reset", 1'b1, 2'd1, 2'd0, 1'b1);
    reset = 1'b1;
    expect_now("async_reset", 1'b0, 2'd0, 2'd0, 1'b0);
    next_cycle();
    reset = 1'b0;

    #5;
    if (exp_q.size() != 0) begin
      miscompares += exp_q.size();
      $display("FAIL leftover: %0d expectations never checked, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
